// File: rtl/legv8_cpu_sc.sv
// ---------------------------------------------------------------------------
// legv8_cpu_sc : single-cycle LEGv8 datapath/control core
//
// Owns the program counter, instruction decode, ALU, branch resolution and
// the writeback mux. Instruction memory, register file and data memory are
// external. The core drives their addresses and controls and consumes their
// read data combinationally. Only the PC is state. Every instruction
// completes in one CLOCK cycle.
//
// Ports
//   CLOCK            in   1  clock, PC updates on the rising edge
//   RESET            in   1  asynchronous active-high reset (PC -> 0)
//   INSTRUCTION      in  32  instruction at PC (combinational imem)
//   REG_DATA1        in  64  regfile read data for READ_REG_1
//   REG_DATA2        in  64  regfile read data for READ_REG_2
//   data_memory_out  in  64  dmem read data at ALU_Result_Out
//   READ_REG_1       out  5  Rn
//   READ_REG_2       out  5  REG2LOC ? Rt : Rm
//   WRITE_REG        out  5  Rd/Rt
//   ALU_Result_Out   out 64  ALU result, also the dmem address
//   WRITE_REG_DATA   out 64  MemtoReg ? data_memory_out : ALU_Result_Out
//   PC               out 64  current program counter (registered)
//   REG2LOC, REGWRITE, MEMREAD, MEMWRITE, BRANCH  out 1  decoded controls
//
// Configuration
//   CPU_SC_IMM_ARITH_EN : when defined, the core also decodes ADDI and SUBI
//                         (zero-extended imm12). When it is undefined, those
//                         encodings decode as NOP.
// ---------------------------------------------------------------------------
module legv8_cpu_sc (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic [63:0] REG_DATA1,
  input  logic [63:0] REG_DATA2,
  input  logic [63:0] data_memory_out,
  output logic [4:0]  READ_REG_1,
  output logic [4:0]  READ_REG_2,
  output logic [4:0]  WRITE_REG,
  output logic [63:0] ALU_Result_Out,
  output logic [63:0] WRITE_REG_DATA,
  output logic [63:0] PC,
  output logic        REG2LOC,
  output logic        REGWRITE,
  output logic        MEMREAD,
  output logic        MEMWRITE,
  output logic        BRANCH
);

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_ORR   = 3'd3,
    ALU_PASSB = 3'd4
  } alu_op_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  logic [63:0] pc_q;
  logic [63:0] pc_d;

  logic        reg2loc_s;
  logic        alusrc_s;
  logic        imm12_sel_s;   // ALUSrc picks imm12 instead of imm9
  logic        memtoreg_s;
  logic        regwrite_s;
  logic        memread_s;
  logic        memwrite_s;
  logic        branch_s;
  logic        uncond_s;
  alu_op_e     alu_op_s;

  logic        is_addi_s;
  logic        is_subi_s;

  logic [63:0] imm9_sext_s;
  logic [63:0] imm12_zext_s;
  logic [63:0] br26_off_s;
  logic [63:0] cbz19_off_s;
  logic [63:0] alu_b_s;
  logic [63:0] alu_res_s;
  logic        alu_zero_s;

`ifdef CPU_SC_IMM_ARITH_EN
  assign is_addi_s = (INSTRUCTION[31:22] == 10'b1001000100);
  assign is_subi_s = (INSTRUCTION[31:22] == 10'b1101000100);
`else
  assign is_addi_s = 1'b0;
  assign is_subi_s = 1'b0;
`endif

  // Immediate fields. Branch offsets are word offsets, so they are shifted left by two.
  assign imm9_sext_s  = {{55{INSTRUCTION[20]}}, INSTRUCTION[20:12]};
  assign imm12_zext_s = {52'd0, INSTRUCTION[21:10]};
  assign br26_off_s   = {{36{INSTRUCTION[25]}}, INSTRUCTION[25:0], 2'b00};
  assign cbz19_off_s  = {{43{INSTRUCTION[23]}}, INSTRUCTION[23:5], 2'b00};

  // Main decoder. Unrecognised encodings fall through to all-zero controls (NOP).
  always_comb begin
    reg2loc_s   = 1'b0;
    alusrc_s    = 1'b0;
    imm12_sel_s = 1'b0;
    memtoreg_s  = 1'b0;
    regwrite_s  = 1'b0;
    memread_s   = 1'b0;
    memwrite_s  = 1'b0;
    branch_s    = 1'b0;
    uncond_s    = 1'b0;
    alu_op_s    = ALU_ADD;
    if (INSTRUCTION[31:21] == OPC_ADD) begin
      regwrite_s = 1'b1;
      alu_op_s   = ALU_ADD;
    end else if (INSTRUCTION[31:21] == OPC_SUB) begin
      regwrite_s = 1'b1;
      alu_op_s   = ALU_SUB;
    end else if (INSTRUCTION[31:21] == OPC_AND) begin
      regwrite_s = 1'b1;
      alu_op_s   = ALU_AND;
    end else if (INSTRUCTION[31:21] == OPC_ORR) begin
      regwrite_s = 1'b1;
      alu_op_s   = ALU_ORR;
    end else if (INSTRUCTION[31:21] == OPC_LDUR) begin
      alusrc_s   = 1'b1;
      memtoreg_s = 1'b1;
      regwrite_s = 1'b1;
      memread_s  = 1'b1;
      alu_op_s   = ALU_ADD;
    end else if (INSTRUCTION[31:21] == OPC_STUR) begin
      reg2loc_s  = 1'b1;
      alusrc_s   = 1'b1;
      memwrite_s = 1'b1;
      alu_op_s   = ALU_ADD;
    end else if (INSTRUCTION[31:24] == OPC_CBZ) begin
      reg2loc_s  = 1'b1;
      branch_s   = 1'b1;
      alu_op_s   = ALU_PASSB;   // zero test on Rt
    end else if (INSTRUCTION[31:26] == OPC_B) begin
      uncond_s   = 1'b1;
    end else if (is_addi_s || is_subi_s) begin
      alusrc_s    = 1'b1;
      imm12_sel_s = 1'b1;
      regwrite_s  = 1'b1;
      alu_op_s    = is_subi_s ? ALU_SUB : ALU_ADD;
    end else begin
      alu_op_s   = ALU_ADD;
    end
  end

  assign alu_b_s = alusrc_s ? (imm12_sel_s ? imm12_zext_s : imm9_sext_s) : REG_DATA2;

  // ALU. All arithmetic wraps modulo 2^64.
  always_comb begin
    alu_res_s = 64'd0;
    case (alu_op_s)
      ALU_ADD:   alu_res_s = REG_DATA1 + alu_b_s;
      ALU_SUB:   alu_res_s = REG_DATA1 - alu_b_s;
      ALU_AND:   alu_res_s = REG_DATA1 & alu_b_s;
      ALU_ORR:   alu_res_s = REG_DATA1 | alu_b_s;
      ALU_PASSB: alu_res_s = alu_b_s;
      default:   alu_res_s = 64'd0;
    endcase
  end

  assign alu_zero_s = (alu_res_s == 64'd0);

  // Next-PC selection. For CBZ the ALU passes Rt through, so alu_zero_s means Rt==0.
  always_comb begin
    pc_d = pc_q + 64'd4;
    if (uncond_s) begin
      pc_d = pc_q + br26_off_s;
    end else if (branch_s && alu_zero_s) begin
      pc_d = pc_q + cbz19_off_s;
    end else begin
      pc_d = pc_q + 64'd4;
    end
  end

  // Program counter. This is the only state in the core.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc_q <= 64'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC             = pc_q;
  assign READ_REG_1     = INSTRUCTION[9:5];
  assign READ_REG_2     = reg2loc_s ? INSTRUCTION[4:0] : INSTRUCTION[20:16];
  assign WRITE_REG      = INSTRUCTION[4:0];
  assign ALU_Result_Out = alu_res_s;
  assign WRITE_REG_DATA = memtoreg_s ? data_memory_out : alu_res_s;
  assign REG2LOC        = reg2loc_s;
  // Architectural writes are blocked while reset is held.
  assign REGWRITE       = regwrite_s & ~RESET;
  assign MEMWRITE       = memwrite_s & ~RESET;
  assign MEMREAD        = memread_s;
  assign BRANCH         = branch_s;

endmodule

// File: tb/tb_legv8_cpu_sc.sv
// ---------------------------------------------------------------------------
// tb_legv8_cpu_sc : directed bench for legv8_cpu_sc
//
// Each step drives the inputs and pushes the expected values onto a
// scoreboard queue. Once the outputs have settled, the bench pops the
// queue and compares each entry with an immediate assertion.
// ---------------------------------------------------------------------------
module tb_legv8_cpu_sc;

  logic        CLOCK;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [63:0] REG_DATA1;
  logic [63:0] REG_DATA2;
  logic [63:0] data_memory_out;
  logic [4:0]  READ_REG_1;
  logic [4:0]  READ_REG_2;
  logic [4:0]  WRITE_REG;
  logic [63:0] ALU_Result_Out;
  logic [63:0] WRITE_REG_DATA;
  logic [63:0] PC;
  logic        REG2LOC;
  logic        REGWRITE;
  logic        MEMREAD;
  logic        MEMWRITE;
  logic        BRANCH;

  legv8_cpu_sc dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .INSTRUCTION(INSTRUCTION),
    .REG_DATA1(REG_DATA1),
    .REG_DATA2(REG_DATA2),
    .data_memory_out(data_memory_out),
    .READ_REG_1(READ_REG_1),
    .READ_REG_2(READ_REG_2),
    .WRITE_REG(WRITE_REG),
    .ALU_Result_Out(ALU_Result_Out),
    .WRITE_REG_DATA(WRITE_REG_DATA),
    .PC(PC),
    .REG2LOC(REG2LOC),
    .REGWRITE(REGWRITE),
    .MEMREAD(MEMREAD),
    .MEMWRITE(MEMWRITE),
    .BRANCH(BRANCH)
  );

  localparam logic [31:0] I_NOP   = 32'h0000_0000;
  localparam logic [31:0] I_ADD   = 32'h8B02_0023;
  localparam logic [31:0] I_SUB   = 32'hCB02_0023;
  localparam logic [31:0] I_AND   = 32'h8A02_0023;
  localparam logic [31:0] I_ORR   = 32'hAA02_0023;
  localparam logic [31:0] I_LDUR  = 32'hF840_8022;
  localparam logic [31:0] I_STUR  = 32'hF81F_8022;
  localparam logic [31:0] I_CBZ   = 32'hB400_0065;
  localparam logic [31:0] I_BM2   = 32'h17FF_FFFE;
  localparam logic [31:0] I_BM3   = 32'h17FF_FFFD;
  localparam logic [31:0] I_ADDI  = 32'h9100_4023;   // ADDI X3,X1,#16

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic push_exp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected <none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [63:0] exp_pc);
    push_exp(tag, exp_pc);
    pop_cmp(PC);
  endtask

  // Pulse RESET between clock edges and bring PC back to 8.
  task automatic reset_to_8();
    #3;
    RESET = 1'b1;
    #1;
    chk_pc("async_reset_pc", 64'd0);
    INSTRUCTION = I_NOP;
    #1;
    RESET = 1'b0;
    tick();
    chk_pc("restart_pc4", 64'd4);
    tick();
    chk_pc("restart_pc8", 64'd8);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET = 1'b1;
    INSTRUCTION = I_ADD;
    REG_DATA1 = 64'd0;
    REG_DATA2 = 64'd0;
    data_memory_out = 64'd0;

    // Reset held: PC stays at 0 and writes are blocked.
    repeat (2) @(posedge CLOCK);
    #1;
    chk_pc("reset_pc", 64'd0);
    push_exp("reset_regwrite", 64'd0);
    pop_cmp({63'd0, REGWRITE});
    INSTRUCTION = I_STUR;
    #1;
    push_exp("reset_memwrite", 64'd0);
    pop_cmp({63'd0, MEMWRITE});

    // Release reset. PC steps 0, 4, 8.
    INSTRUCTION = I_NOP;
    RESET = 1'b0;
    #1;
    chk_pc("release_pc0", 64'd0);
    tick();
    chk_pc("release_pc4", 64'd4);
    tick();
    chk_pc("release_pc8", 64'd8);

    // Assert reset asynchronously mid-cycle.
    #2;
    RESET = 1'b1;
    INSTRUCTION = I_ADD;
    #1;
    chk_pc("midcycle_reset_pc", 64'd0);
    push_exp("midcycle_regwrite", 64'd0);
    pop_cmp({63'd0, REGWRITE});
    INSTRUCTION = I_STUR;
    #1;
    push_exp("midcycle_memwrite", 64'd0);
    pop_cmp({63'd0, MEMWRITE});
    INSTRUCTION = I_NOP;
    #1;
    RESET = 1'b0;
    tick();
    chk_pc("rerun_pc4", 64'd4);
    tick();
    chk_pc("rerun_pc8", 64'd8);

    // ADD X3,X1,X2 with operands 5 and 7.
    INSTRUCTION = I_ADD;
    REG_DATA1 = 64'd5;
    REG_DATA2 = 64'd7;
    push_exp("add_rr1", 64'd1);
    push_exp("add_rr2", 64'd2);
    push_exp("add_wr", 64'd3);
    push_exp("add_alu", 64'd12);
    push_exp("add_regwrite", 64'd1);
    push_exp("add_wrdata", 64'd12);
    #1;
    pop_cmp({59'd0, READ_REG_1});
    pop_cmp({59'd0, READ_REG_2});
    pop_cmp({59'd0, WRITE_REG});
    pop_cmp(ALU_Result_Out);
    pop_cmp({63'd0, REGWRITE});
    pop_cmp(WRITE_REG_DATA);

    // SUB, AND and ORR with the same operands.
    tick();
    INSTRUCTION = I_SUB;
    push_exp("sub_alu_wrap", 64'hFFFF_FFFF_FFFF_FFFE);
    #1;
    pop_cmp(ALU_Result_Out);
    INSTRUCTION = I_AND;
    push_exp("and_alu", 64'd5);
    #1;
    pop_cmp(ALU_Result_Out);
    INSTRUCTION = I_ORR;
    push_exp("orr_alu", 64'd7);
    #1;
    pop_cmp(ALU_Result_Out);

    // ADDI decodes only when the immediate-arithmetic build option is on.
    tick();
    INSTRUCTION = I_ADDI;
`ifdef CPU_SC_IMM_ARITH_EN
    push_exp("addi_regwrite", 64'd1);
    push_exp("addi_alu", 64'd21);
    #1;
    pop_cmp({63'd0, REGWRITE});
    pop_cmp(ALU_Result_Out);
`else
    push_exp("addi_as_nop_regwrite", 64'd0);
    #1;
    pop_cmp({63'd0, REGWRITE});
`endif

    // LDUR X2,[X1,#8]
    tick();
    INSTRUCTION = I_LDUR;
    REG_DATA1 = 64'h10;
    data_memory_out = 64'hAB;
    push_exp("ldur_alu", 64'h18);
    push_exp("ldur_memread", 64'd1);
    push_exp("ldur_wrdata", 64'hAB);
    push_exp("ldur_regwrite", 64'd1);
    #1;
    pop_cmp(ALU_Result_Out);
    pop_cmp({63'd0, MEMREAD});
    pop_cmp(WRITE_REG_DATA);
    pop_cmp({63'd0, REGWRITE});

    // STUR X2,[X1,#-8]
    tick();
    INSTRUCTION = I_STUR;
    REG_DATA1 = 64'h20;
    push_exp("stur_alu", 64'h18);
    push_exp("stur_memwrite", 64'd1);
    push_exp("stur_regwrite", 64'd0);
    push_exp("stur_reg2loc", 64'd1);
    push_exp("stur_rr2", 64'd2);
    #1;
    pop_cmp(ALU_Result_Out);
    pop_cmp({63'd0, MEMWRITE});
    pop_cmp({63'd0, REGWRITE});
    pop_cmp({63'd0, REG2LOC});
    pop_cmp({59'd0, READ_REG_2});

    // CBZ X5,#+3 taken at PC=8.
    reset_to_8();
    INSTRUCTION = I_CBZ;
    REG_DATA2 = 64'd0;
    push_exp("cbz_branch", 64'd1);
    push_exp("cbz_rr2", 64'd5);
    #1;
    pop_cmp({63'd0, BRANCH});
    pop_cmp({59'd0, READ_REG_2});
    tick();
    chk_pc("cbz_taken_pc", 64'd20);

    // CBZ not taken at PC=8.
    reset_to_8();
    INSTRUCTION = I_CBZ;
    REG_DATA2 = 64'd1;
    tick();
    chk_pc("cbz_not_taken_pc", 64'd12);

    // An undefined encoding behaves as a NOP.
    INSTRUCTION = I_NOP;
    push_exp("nop_controls", 64'd0);
    #1;
    pop_cmp({59'd0, REG2LOC, REGWRITE, MEMREAD, MEMWRITE, BRANCH});
    tick();
    chk_pc("nop_pc16", 64'd16);

    // B #-2 at PC=16 goes back to 8. B #-3 at PC=8 wraps below zero.
    INSTRUCTION = I_BM2;
    tick();
    chk_pc("b_back_pc8", 64'd8);
    INSTRUCTION = I_BM3;
    tick();
    chk_pc("b_wrap_pc", 64'hFFFF_FFFF_FFFF_FFFC);
    INSTRUCTION = I_NOP;
    tick();
    chk_pc("pc_wrap_zero", 64'd0);

    checks++;
    assert (sb_q.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
